button_event_arbiter: RTL and testbench

Converts N debounced, synchronized button levels into a single serialized event stream. Each button can raise three event types: press, long-press and release. A round-robin arbiter drains the pending events through one registered valid/ready port. The block sits between the per-button synchronizer/debouncer chains and the display/mode controller, which consumes one event at a time.

---
 rtl/btn_evt_pkg.sv | 32 +++
 rtl/btn_evt_channel.sv | 68 ++++++
 rtl/button_event_arbiter.sv | 110 +++++++++++
 tb/tb_button_event_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event codes, pending-bit positions and output-slot states for the
// button event arbiter.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_LONG    = 2'b11;

  localparam int PEND_P = 0;
  localparam int PEND_L = 1;
  localparam int PEND_R = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Press before long before release keeps each button's events in causal order.
  function automatic logic [2:0] pendPick(input logic [2:0] pend);
    if (pend[PEND_P])      return 3'b001;
    else if (pend[PEND_L]) return 3'b010;
    else if (pend[PEND_R]) return 3'b100;
    else                   return 3'b000;
  endfunction

  function automatic logic [1:0] pendToType(input logic [2:0] pend);
    if (pend[PEND_P])      return EVT_PRESS;
    else if (pend[PEND_L]) return EVT_LONG;
    else                   return EVT_RELEASE;
  endfunction

endpackage

// File: rtl/btn_evt_channel.sv
// One button: edge detection, hold counter for long-press, the three pending
// event bits and the sticky overrun flag.
module btn_evt_channel
  import btn_evt_pkg::*;
#(
  parameter int LONG_TIME = 50000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level_i,
  input  logic       enable_i,
  input  logic [2:0] grant_i,
  input  logic       overrun_clr_i,
  output logic [2:0] pending_o,
  output logic       overrun_o
);

  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_TIME);

  logic             prev_q;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic [2:0]       pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [2:0]       raise;
  logic             pressEdge, releaseEdge;

  assign pressEdge   = level_i & ~prev_q;
  assign releaseEdge = ~level_i & prev_q;

  // The counter saturates at LONG_TIME so the long event can only fire once per press.
  always_comb begin
    raise     = '0;
    holdCnt_d = '0;
    if (enable_i) begin
      raise[PEND_P] = pressEdge;
      raise[PEND_R] = releaseEdge;
      if (level_i && !pressEdge) begin
        if (holdCnt_q < LONG_CNT) begin
          holdCnt_d     = holdCnt_q + 1'b1;
          raise[PEND_L] = (holdCnt_d == LONG_CNT);
        end else begin
          holdCnt_d = holdCnt_q;
        end
      end
    end
    pend_d = enable_i ? (raise | (pend_q & ~grant_i)) : 3'b000;
    ovr_d  = (|(raise & pend_q & ~grant_i)) | (ovr_q & ~overrun_clr_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= 1'b0;
      holdCnt_q <= '0;
      pend_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      prev_q    <= level_i;
      holdCnt_q <= holdCnt_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Serializes press/long/release events from several buttons into one
// registered valid/ready stream using a round-robin search.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  parameter int IDX_W       = 2,
  parameter int LONG_TIME   = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] btn_level,
  input  logic                   enable,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDX_W-1:0]       evt_btn,
  output logic [1:0]             evt_type,
  output logic [NUM_BUTTONS-1:0] overrun,
  input  logic                   overrun_clr
);

  logic [2:0]       pending [NUM_BUTTONS];
  logic [2:0]       grant   [NUM_BUTTONS];
  slot_state_e      slot_q, slot_d;
  logic [IDX_W-1:0] btn_q, btn_d;
  logic [1:0]       type_q, type_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] selIdx, candIdx;
  logic [2:0]       selPick;
  logic             found, load;
  int               cand;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : gChan
    btn_evt_channel #(
      .LONG_TIME(LONG_TIME),
      .CNT_W    (CNT_W)
    ) uChan (
      .clk          (clk),
      .reset_n      (reset_n),
      .level_i      (btn_level[g]),
      .enable_i     (enable),
      .grant_i      (grant[g]),
      .overrun_clr_i(overrun_clr),
      .pending_o    (pending[g]),
      .overrun_o    (overrun[g])
    );
  end

  always_comb begin
    found   = 1'b0;
    selIdx  = '0;
    cand    = 0;
    candIdx = '0;
    for (int off = 0; off < NUM_BUTTONS; off++) begin
      cand = int'(rrPtr_q) + off;
      if (cand >= NUM_BUTTONS) cand = cand - NUM_BUTTONS;
      candIdx = IDX_W'(cand);
      if (!found && (|pending[candIdx])) begin
        found  = 1'b1;
        selIdx = candIdx;
      end
    end
  end

  assign load = found && ((slot_q == SLOT_EMPTY) || evt_ready);

  // A free or draining slot takes the granted event on the same edge its pending bit clears.
  always_comb begin
    slot_d  = slot_q;
    btn_d   = btn_q;
    type_d  = type_q;
    rrPtr_d = rrPtr_q;
    selPick = '0;
    if (load) begin
      selPick = pendPick(pending[selIdx]);
      slot_d  = SLOT_FULL;
      btn_d   = selIdx;
      type_d  = pendToType(pending[selIdx]);
      rrPtr_d = (int'(selIdx) == NUM_BUTTONS - 1) ? '0 : selIdx + 1'b1;
    end else if ((slot_q == SLOT_FULL) && evt_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      grant[i] = (load && (selIdx == IDX_W'(i))) ? selPick : 3'b000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= SLOT_EMPTY;
      btn_q   <= '0;
      type_q  <= '0;
      rrPtr_q <= '0;
    end else begin
      slot_q  <= slot_d;
      btn_q   <= btn_d;
      type_q  <= type_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  assign evt_valid = (slot_q == SLOT_FULL);
  assign evt_btn   = btn_q;
  assign evt_type  = type_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: directed button sequences push
// hand-derived events, a negedge monitor pops them on each transfer.
module tb_button_event_arbiter;
  import btn_evt_pkg::*;

  typedef struct packed {
    logic [1:0] btn;
    logic [1:0] typ;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_level = 4'b0000;
  logic       enable = 1'b1;
  logic       evt_ready = 1'b1;
  logic       overrun_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic [3:0] overrun;

  evt_t expQ[$];
  evt_t monEvt;
  int   checks = 0;
  int   errors = 0;

  button_event_arbiter #(
    .NUM_BUTTONS(4),
    .IDX_W      (2),
    .LONG_TIME  (20),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_level  (btn_level),
    .enable     (enable),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_btn    (evt_btn),
    .evt_type   (evt_type),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] lvl, input int cycles);
    btn_level = lvl;
    step(cycles);
  endtask

  task automatic pushExp(input logic [1:0] b, input logic [1:0] t);
    expQ.push_back('{btn: b, typ: t});
  endtask

  // Every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got btn %0d type %0d expected none", evt_btn, evt_type);
      end else begin
        monEvt = expQ.pop_front();
        checkOutput("scoreboard", {28'd0, evt_btn, evt_type}, {28'd0, monEvt.btn, monEvt.typ});
      end
    end
  end

  initial begin
    step(2);
    checkOutput("reset_outputs", {evt_valid, evt_btn, evt_type, overrun}, 9'd0);
    reset_n = 1'b1;
    step(3);

    // single press/release on button 2
    pushExp(2'd2, EVT_PRESS);
    applyStimulus(4'b0100, 1);
    checkOutput("press_latency", {31'd0, evt_valid}, 32'd0);
    step(1);
    checkOutput("press_valid", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd2, EVT_PRESS});
    step(3);
    pushExp(2'd2, EVT_RELEASE);
    applyStimulus(4'b0000, 2);
    checkOutput("release_valid", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd2, EVT_RELEASE});
    step(30);

    // long press on button 0
    pushExp(2'd0, EVT_PRESS);
    pushExp(2'd0, EVT_LONG);
    applyStimulus(4'b0001, 1);
    step(20);
    checkOutput("long_not_early", {31'd0, evt_valid}, 32'd0);
    step(1);
    checkOutput("long_valid", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd0, EVT_LONG});
    step(9);
    pushExp(2'd0, EVT_RELEASE);
    applyStimulus(4'b0000, 30);

    // round robin from pointer 0 after a reset
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) pushExp(2'(i), EVT_PRESS);
    applyStimulus(4'b1111, 1);
    step(4);
    checkOutput("rr_consecutive", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd3, EVT_PRESS});
    step(2);
    for (int i = 0; i < 4; i++) pushExp(2'(i), EVT_RELEASE);
    applyStimulus(4'b0000, 6);
    pushExp(2'd1, EVT_PRESS);
    applyStimulus(4'b0010, 3);
    pushExp(2'd1, EVT_RELEASE);
    applyStimulus(4'b0000, 3);
    for (int i = 0; i < 4; i++) pushExp(2'((i + 2) % 4), EVT_PRESS);
    applyStimulus(4'b1111, 2);
    checkOutput("rr_start_at_2", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd2, EVT_PRESS});
    step(4);
    for (int i = 0; i < 4; i++) pushExp(2'((i + 2) % 4), EVT_RELEASE);
    applyStimulus(4'b0000, 6);

    // backpressure holds the presented event
    evt_ready = 1'b0;
    pushExp(2'd3, EVT_PRESS);
    pushExp(2'd0, EVT_PRESS);
    applyStimulus(4'b1001, 2);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_stable", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd3, EVT_PRESS});
      step(1);
    end
    evt_ready = 1'b1;
    step(1);
    checkOutput("after_stall_next", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd0, EVT_PRESS});
    step(2);
    pushExp(2'd3, EVT_RELEASE);
    pushExp(2'd0, EVT_RELEASE);
    applyStimulus(4'b0000, 5);

    // overrun on button 1 while the slot is blocked
    evt_ready = 1'b0;
    applyStimulus(4'b1000, 2);
    applyStimulus(4'b1010, 1);
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b1010, 1);
    checkOutput("overrun_set", {28'd0, overrun}, 32'h2);
    applyStimulus(4'b1000, 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checkOutput("overrun_clear", {28'd0, overrun}, 32'h0);
    applyStimulus(4'b0000, 1);
    pushExp(2'd3, EVT_PRESS);
    pushExp(2'd1, EVT_PRESS);
    pushExp(2'd3, EVT_RELEASE);
    pushExp(2'd1, EVT_RELEASE);
    evt_ready = 1'b1;
    step(6);

    // asynchronous reset with a full slot and pending events
    evt_ready = 1'b0;
    applyStimulus(4'b0101, 3);
    checkOutput("pre_reset_full", {31'd0, evt_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", {evt_valid, evt_btn, evt_type, overrun}, 9'd0);
    step(2);
    reset_n = 1'b1;
    pushExp(2'd0, EVT_PRESS);
    pushExp(2'd2, EVT_PRESS);
    evt_ready = 1'b1;
    step(5);
    pushExp(2'd0, EVT_RELEASE);
    pushExp(2'd2, EVT_RELEASE);
    applyStimulus(4'b0000, 5);

    // disabled input produces nothing
    enable = 1'b0;
    applyStimulus(4'b0010, 3);
    applyStimulus(4'b0000, 3);
    checkOutput("enable_off", {31'd0, evt_valid}, 32'd0);
    enable = 1'b1;
    step(10);

    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
